// File: rtl/cpu_run_ctrl.sv
// Run/step/halt sequencer: turns two raw buttons, a speed select and the CPU halt flag
// into a train of one-cycle CPU clock-enable pulses.

module cpu_run_ctrl_deb #(
    parameter int DEB_W = 16
) (
    input  logic clk,
    input  logic reset_n_i,
    input  logic raw,
    output logic press
);
    localparam logic [DEB_W-1:0] DEB_ONE = DEB_W'(1);

    logic             sync1, sync2, level;
    logic [DEB_W-1:0] cnt;

    // press fires on the same edge the level flips, so raw rise to state change is 2**DEB_W+3 edges
    always_ff @(posedge clk) begin
        if (!reset_n_i) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (&cnt) begin
                cnt   <= '0;
                level <= sync2;
                press <= sync2;
            end else begin
                cnt <= cnt + DEB_ONE;
            end
        end
    end
endmodule

module cpu_run_ctrl #(
    parameter int DIV_W = 19,
    parameter int DEB_W = 16
) (
    input  logic        clk,
    input  logic        reset_n_i,
    input  logic        run_btn_i,
    input  logic        step_btn_i,
    input  logic [1:0]  speed_sel_i,
    input  logic        halt_i,
    output logic        clk_en_o,
    output logic [1:0]  state_o,
    output logic [15:0] en_count_o
);
    localparam int NUM_BTN = 2;
    localparam logic [DIV_W-1:0] MASK_MID  = DIV_W'((1 << (DIV_W - 4)) - 1);
    localparam logic [DIV_W-1:0] MASK_FAST = DIV_W'((1 << (DIV_W - 8)) - 1);
    localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);

    typedef enum logic [1:0] {PAUSE = 2'd0, RUN = 2'd1, STEP = 2'd2, HALTED = 2'd3} state_t;

    state_t             state, state_nxt;
    logic [NUM_BTN-1:0] btn_raw, press_evt;
    logic [DIV_W-1:0]   cnt, tick_mask;
    logic               tick, run_evt, step_evt;

    assign btn_raw  = {step_btn_i, run_btn_i};
    assign run_evt  = press_evt[0];
    assign step_evt = press_evt[1];

    for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
        cpu_run_ctrl_deb #(.DEB_W(DEB_W)) u_deb (
            .clk       (clk),
            .reset_n_i (reset_n_i),
            .raw       (btn_raw[b]),
            .press     (press_evt[b])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset_n_i) state <= PAUSE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (halt_i && state != STEP) begin
            state_nxt = HALTED;
        end else begin
            case (state)
                PAUSE:   if (run_evt) state_nxt = RUN;
                         else if (step_evt) state_nxt = STEP;
                RUN:     if (run_evt) state_nxt = PAUSE;
                STEP:    state_nxt = halt_i ? HALTED : PAUSE;
                HALTED:  state_nxt = PAUSE;
                default: state_nxt = PAUSE;
            endcase
        end
    end

    always_comb begin
        case (speed_sel_i)
            2'd0:    tick_mask = '1;
            2'd1:    tick_mask = MASK_MID;
            2'd2:    tick_mask = MASK_FAST;
            default: tick_mask = '0;
        endcase
        tick     = ~|(cnt & tick_mask);
        // reset gates the enable combinationally so a pulse cannot leak during the reset cycle
        clk_en_o = reset_n_i & ((state == STEP) | ((state == RUN) & tick & ~halt_i));
        state_o  = state;
    end

    always_ff @(posedge clk) begin
        if (!reset_n_i)                          cnt <= '0;
        else if (state == RUN && state_nxt == RUN) cnt <= cnt + DIV_ONE;
        else                                     cnt <= '0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n_i)    en_count_o <= '0;
        else if (clk_en_o) en_count_o <= en_count_o + 16'd1;
    end
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: window-based behavioural model compared every cycle, plus
// directed scenarios with hand-computed timing expectations and a random phase.

module tb_cpu_run_ctrl;
    localparam int DIV_W = 10;
    localparam int DEB_W = 2;
    localparam int N     = 1 << DEB_W;

    logic        clk = 1'b0;
    logic        reset_n_i = 1'b0, run_btn_i = 1'b0, step_btn_i = 1'b0, halt_i = 1'b0;
    logic [1:0]  speed_sel_i = 2'd0;
    logic        clk_en_o;
    logic [1:0]  state_o;
    logic [15:0] en_count_o;

    int errors = 0, checks = 0, cyc = 0;
    int pulses[$];

    always #5 clk = ~clk;

    cpu_run_ctrl #(.DIV_W(DIV_W), .DEB_W(DEB_W)) dut (
        .clk         (clk),
        .reset_n_i   (reset_n_i),
        .run_btn_i   (run_btn_i),
        .step_btn_i  (step_btn_i),
        .speed_sel_i (speed_sel_i),
        .halt_i      (halt_i),
        .clk_en_o    (clk_en_o),
        .state_o     (state_o),
        .en_count_o  (en_count_o)
    );

    // Model: state 0=PAUSE 1=RUN 2=STEP 3=HALTED; m_rc = cycles spent in the current RUN stay.
    bit m_valid = 0;
    int m_state = 0, m_rc = 0, m_cnt = 0;
    bit m_sync1[2], m_sync2[2], m_lvl[2], m_evt[2];
    bit m_win[2][N];

    function automatic bit m_en();
        int period;
        case (speed_sel_i)
            2'd0:    period = 1 << DIV_W;
            2'd1:    period = 1 << (DIV_W - 4);
            2'd2:    period = 1 << (DIV_W - 8);
            default: period = 1;
        endcase
        return reset_n_i && m_valid &&
               (m_state == 2 || (m_state == 1 && (m_rc % period) == 0 && !halt_i));
    endfunction

    always @(posedge clk) begin
        bit en, alldiff;
        int nxt;
        bit btn[2];
        cyc++;
        if (!reset_n_i) begin
            m_valid = 1; m_state = 0; m_rc = 0; m_cnt = 0;
            for (int b = 0; b < 2; b++) begin
                m_sync1[b] = 0; m_sync2[b] = 0; m_lvl[b] = 0; m_evt[b] = 0;
                for (int i = 0; i < N; i++) m_win[b][i] = 0;
            end
        end else begin
            en = m_en();
            if (en) m_cnt = (m_cnt + 1) % 65536;
            nxt = m_state;
            if (halt_i && m_state != 2) nxt = 3;
            else case (m_state)
                0: if (m_evt[0]) nxt = 1; else if (m_evt[1]) nxt = 2;
                1: if (m_evt[0]) nxt = 0;
                2: nxt = halt_i ? 3 : 0;
                default: nxt = 0;
            endcase
            m_rc = (nxt == 1) ? ((m_state == 1) ? m_rc + 1 : 0) : 0;
            m_state = nxt;
            btn[0] = run_btn_i; btn[1] = step_btn_i;
            // level flips once the last N synchronized samples all disagree with it
            for (int b = 0; b < 2; b++) begin
                for (int i = N - 1; i > 0; i--) m_win[b][i] = m_win[b][i-1];
                m_win[b][0] = m_sync2[b];
                alldiff = 1;
                for (int i = 0; i < N; i++) if (m_win[b][i] == m_lvl[b]) alldiff = 0;
                m_evt[b] = 0;
                if (alldiff) begin
                    m_lvl[b] = !m_lvl[b];
                    m_evt[b] = m_lvl[b];
                end
                m_sync2[b] = m_sync1[b];
                m_sync1[b] = btn[b];
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_clk_en", {31'd0, clk_en_o}, {31'd0, m_en()});
            check("model_state", {30'd0, state_o}, m_state);
            check("model_en_count", {16'd0, en_count_o}, m_cnt);
            if (clk_en_o === 1'b1) pulses.push_back(cyc);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic press(input int b, input int hold);
        if (b == 0) run_btn_i = 1'b1; else step_btn_i = 1'b1;
        tick(hold);
        run_btn_i = 1'b0;
        step_btn_i = 1'b0;
    endtask

    initial begin
        int c0, r;
        int periods[4];
        periods[0] = 1024; periods[1] = 64; periods[2] = 4; periods[3] = 1;

        // reset with buttons toggling
        for (int i = 0; i < 5; i++) begin
            run_btn_i = i[0]; step_btn_i = !i[0];
            tick(1);
        end
        run_btn_i = 0; step_btn_i = 0;
        check("rst_state", {30'd0, state_o}, 0);
        check("rst_clk_en", {31'd0, clk_en_o}, 0);
        check("rst_count", {16'd0, en_count_o}, 0);
        reset_n_i = 1;
        tick(12);
        check("rst_no_press", {30'd0, state_o}, 0);
        check("rst_no_pulse", pulses.size(), 0);

        // single step: pulse 7 edges after raw rise
        c0 = cyc;
        press(1, 8);
        tick(20);
        check("step_npulse", pulses.size(), 1);
        if (pulses.size() > 0) check("step_latency", pulses[0] - c0, 7);
        check("step_count", {16'd0, en_count_o}, 1);
        check("step_back_pause", {30'd0, state_o}, 0);
        pulses.delete();
        press(1, 3);
        tick(20);
        check("glitch_no_pulse", pulses.size(), 0);

        // run rates
        for (int s = 0; s < 4; s++) begin
            speed_sel_i = 2'(s);
            pulses.delete();
            c0 = cyc;
            press(0, 8);
            tick(2 * periods[s] + 20);
            if (pulses.size() >= 2) begin
                check("run_first", pulses[0] - c0, 7);
                check("run_spacing", pulses[1] - pulses[0], periods[s]);
            end else check("run_two_pulses", pulses.size(), 2);
            press(0, 8);
            tick(20);
            pulses.delete();
            tick(30);
            check("pause_no_pulse", pulses.size(), 0);
            check("pause_state", {30'd0, state_o}, 0);
        end

        // halt while running fast
        speed_sel_i = 2'd3;
        press(0, 8);
        tick(20);
        halt_i = 1;
        pulses.delete();
        #1 check("halt_en_same", {31'd0, clk_en_o}, 0);
        tick(1);
        check("halt_state", {30'd0, state_o}, 3);
        press(0, 8);
        tick(10);
        press(1, 8);
        tick(10);
        check("halt_ignore", {30'd0, state_o}, 3);
        check("halt_no_pulse", pulses.size(), 0);
        halt_i = 0;
        tick(1);
        check("unhalt_state", {30'd0, state_o}, 0);
        tick(10);

        // simultaneous run+step from PAUSE
        run_btn_i = 1; step_btn_i = 1;
        tick(7);
        check("both_run", {30'd0, state_o}, 1);
        tick(1);
        run_btn_i = 0; step_btn_i = 0;
        tick(10);
        press(1, 8);
        tick(10);
        check("step_in_run", {30'd0, state_o}, 1);
        press(0, 8);
        tick(10);
        check("both_pause", {30'd0, state_o}, 0);

        // random phase against the model
        for (int i = 0; i < 250; i++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2: press(0, $urandom_range(1, 9));
                3, 4:    press(1, $urandom_range(1, 9));
                5:       halt_i = ~halt_i;
                6:       speed_sel_i = 2'($urandom_range(0, 3));
                7:       if ($urandom_range(0, 4) == 0) begin
                             reset_n_i = 0; tick(1); reset_n_i = 1;
                         end
                default: ;
            endcase
            tick($urandom_range(1, 12));
        end
        halt_i = 0;

        // counter wrap then reset mid-RUN
        reset_n_i = 0;
        tick(2);
        reset_n_i = 1;
        speed_sel_i = 2'd3;
        tick(2);
        run_btn_i = 1;
        tick(7);
        check("wrap_start", {16'd0, en_count_o}, 0);
        check("wrap_run", {30'd0, state_o}, 1);
        tick(1);
        run_btn_i = 0;
        tick(65535);
        check("wrap_count", {16'd0, en_count_o}, 0);
        reset_n_i = 0;
        #1 check("rst_mid_en", {31'd0, clk_en_o}, 0);
        tick(1);
        check("rst_mid_state", {30'd0, state_o}, 0);
        reset_n_i = 1;
        tick(3);
        check("rst_after_state", {30'd0, state_o}, 0);
        check("rst_after_count", {16'd0, en_count_o}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
